// File: rtl/pe_array_seq.sv
// pe_array_seq: hardware sequencer for the pe_array output-stationary loop nest.
// Loop order is m (output column) outermost, then j (row tile), then i (reduction).
// Each tile streams IA_W activation/weight beats into pe_array. It then pulses the
// clear/readout window and writes one output-buffer word per tile.
module pe_array_seq #(
  parameter int MAC_NUM = 4,
  parameter int BW_ACT  = 8,
  parameter int BW_WET  = 8,
  parameter int IA_H    = 8,
  parameter int IA_W    = 8,
  parameter int OA_W    = 8,
  parameter int PE_LAT  = 2,
  localparam int J_N    = IA_H / MAC_NUM,
  localparam int IA_AW  = (J_N * IA_W > 1) ? $clog2(J_N * IA_W) : 1,
  localparam int WT_AW  = (IA_W * OA_W > 1) ? $clog2(IA_W * OA_W) : 1,
  localparam int OA_AW  = (J_N * OA_W > 1) ? $clog2(J_N * OA_W) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  shift_num,
  output logic                        busy,
  output logic                        done,
  output logic                        ia_rd_en,
  output logic [IA_AW-1:0]            ia_rd_addr,
  input  logic [MAC_NUM*BW_ACT-1:0]   ia_rd_data,
  output logic                        wet_rd_en,
  output logic [WT_AW-1:0]            wet_rd_addr,
  input  logic [BW_WET-1:0]           wet_rd_data,
  output logic                        PE_mac_enable,
  output logic                        PE_clear_acc,
  output logic [MAC_NUM*BW_ACT-1:0]   PE_act_in,
  output logic [BW_WET-1:0]           PE_wet_in,
  output logic [7:0]                  PE_res_shift_num,
  input  logic [MAC_NUM*BW_ACT-1:0]   PE_result_out,
  output logic                        oa_wr_en,
  output logic [OA_AW-1:0]            oa_wr_addr,
  output logic [MAC_NUM*BW_ACT-1:0]   oa_wr_data
);

  localparam int IW = (IA_W > 1) ? $clog2(IA_W) : 1;
  localparam int JW = (J_N > 1) ? $clog2(J_N) : 1;
  localparam int MW = (OA_W > 1) ? $clog2(OA_W) : 1;
  localparam int LW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_CLEAR = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [MW-1:0] m_q, m_d;
  logic [LW-1:0] w_q, w_d;
  logic [7:0]    shift_q, shift_d;

  // Next-state values of the registered outputs, derived from the next FSM state
  logic                   rd_en_d;
  logic [IA_AW-1:0]       ia_addr_d;
  logic [WT_AW-1:0]       wet_addr_d;
  logic                   wr_en_d;
  logic [OA_AW-1:0]       oa_addr_d;
  logic                   clear_d;
  logic                   busy_d;
  logic                   done_d;

  // Output registers
  logic                        busy_q, done_q;
  logic                        ia_rd_en_q, wet_rd_en_q;
  logic [IA_AW-1:0]            ia_rd_addr_q;
  logic [WT_AW-1:0]            wet_rd_addr_q;
  logic                        mac_en_q, clear_q;
  logic [MAC_NUM*BW_ACT-1:0]   act_q;
  logic [BW_WET-1:0]           wet_q;
  logic                        oa_wr_en_q;
  logic [OA_AW-1:0]            oa_wr_addr_q;
  logic [MAC_NUM*BW_ACT-1:0]   oa_wr_data_q;

  // FSM state, loop counters and latched shift amount
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= {IW{1'b0}};
      j_q     <= {JW{1'b0}};
      m_q     <= {MW{1'b0}};
      w_q     <= {LW{1'b0}};
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      m_q     <= m_d;
      w_q     <= w_d;
      shift_q <= shift_d;
    end
  end

  // Loop-nest sequencing: next state and counter updates
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    m_d     = m_q;
    w_d     = w_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          i_d     = {IW{1'b0}};
          j_d     = {JW{1'b0}};
          m_d     = {MW{1'b0}};
          shift_d = shift_num;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FEED: begin
        if (i_q == IW'(IA_W - 1)) begin
          state_d = S_DRAIN;
          i_d     = {IW{1'b0}};
        end else begin
          i_d     = i_q + IW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_WAIT;
        w_d     = {LW{1'b0}};
      end
      S_WAIT: begin
        if (w_q == LW'(PE_LAT - 1)) begin
          state_d = S_WRITE;
        end else begin
          w_d     = w_q + LW'(1);
        end
      end
      S_WRITE: begin
        if (j_q == JW'(J_N - 1)) begin
          j_d = {JW{1'b0}};
          if (m_q == MW'(OA_W - 1)) begin
            m_d     = {MW{1'b0}};
            state_d = S_DONE;
          end else begin
            m_d     = m_q + MW'(1);
            state_d = S_FEED;
          end
        end else begin
          j_d     = j_q + JW'(1);
          state_d = S_FEED;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes and addresses for the coming cycle; addresses stay 0 off-strobe
  always_comb begin
    rd_en_d    = (state_d == S_FEED);
    wr_en_d    = (state_d == S_WRITE);
    clear_d    = (state_d == S_CLEAR) || (state_d == S_WAIT);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    ia_addr_d  = {IA_AW{1'b0}};
    wet_addr_d = {WT_AW{1'b0}};
    oa_addr_d  = {OA_AW{1'b0}};
    if (rd_en_d) begin
      ia_addr_d  = IA_AW'(int'(j_d) * IA_W + int'(i_d));
      wet_addr_d = WT_AW'(int'(i_d) * OA_W + int'(m_d));
    end else begin
      ia_addr_d  = {IA_AW{1'b0}};
      wet_addr_d = {WT_AW{1'b0}};
    end
    if (wr_en_d) begin
      oa_addr_d = OA_AW'(int'(j_d) * OA_W + int'(m_d));
    end else begin
      oa_addr_d = {OA_AW{1'b0}};
    end
  end

  // Registered outputs; buffer data is captured on the edge ending its read strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ia_rd_en_q    <= 1'b0;
      wet_rd_en_q   <= 1'b0;
      ia_rd_addr_q  <= {IA_AW{1'b0}};
      wet_rd_addr_q <= {WT_AW{1'b0}};
      mac_en_q      <= 1'b0;
      clear_q       <= 1'b0;
      act_q         <= {(MAC_NUM*BW_ACT){1'b0}};
      wet_q         <= {BW_WET{1'b0}};
      oa_wr_en_q    <= 1'b0;
      oa_wr_addr_q  <= {OA_AW{1'b0}};
      oa_wr_data_q  <= {(MAC_NUM*BW_ACT){1'b0}};
    end else begin
      busy_q        <= busy_d;
      done_q        <= done_d;
      ia_rd_en_q    <= rd_en_d;
      wet_rd_en_q   <= rd_en_d;
      ia_rd_addr_q  <= ia_addr_d;
      wet_rd_addr_q <= wet_addr_d;
      mac_en_q      <= ia_rd_en_q;
      clear_q       <= clear_d;
      act_q         <= ia_rd_en_q ? ia_rd_data : {(MAC_NUM*BW_ACT){1'b0}};
      wet_q         <= wet_rd_en_q ? wet_rd_data : {BW_WET{1'b0}};
      oa_wr_en_q    <= wr_en_d;
      oa_wr_addr_q  <= oa_addr_d;
      oa_wr_data_q  <= wr_en_d ? PE_result_out : {(MAC_NUM*BW_ACT){1'b0}};
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign ia_rd_en         = ia_rd_en_q;
  assign ia_rd_addr       = ia_rd_addr_q;
  assign wet_rd_en        = wet_rd_en_q;
  assign wet_rd_addr      = wet_rd_addr_q;
  assign PE_mac_enable    = mac_en_q;
  assign PE_clear_acc     = clear_q;
  assign PE_act_in        = act_q;
  assign PE_wet_in        = wet_q;
  assign PE_res_shift_num = shift_q;
  assign oa_wr_en         = oa_wr_en_q;
  assign oa_wr_addr       = oa_wr_addr_q;
  assign oa_wr_data       = oa_wr_data_q;

endmodule

// File: tb/tb_pe_array_seq.sv
// Bench for pe_array_seq: buffer models, a behavioural pe_array and a write scoreboard.
module tb_pe_array_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  shift_num;
  logic        busy, done;
  logic        ia_rd_en, wet_rd_en;
  logic [3:0]  ia_rd_addr;
  logic [5:0]  wet_rd_addr;
  logic [31:0] ia_rd_data;
  logic [7:0]  wet_rd_data;
  logic        PE_mac_enable, PE_clear_acc;
  logic [31:0] PE_act_in;
  logic [7:0]  PE_wet_in;
  logic [7:0]  PE_res_shift_num;
  logic [31:0] PE_result_out;
  logic        oa_wr_en;
  logic [3:0]  oa_wr_addr;
  logic [31:0] oa_wr_data;

  pe_array_seq dut (
    .clk(clk), .reset(reset), .start(start), .shift_num(shift_num),
    .busy(busy), .done(done),
    .ia_rd_en(ia_rd_en), .ia_rd_addr(ia_rd_addr), .ia_rd_data(ia_rd_data),
    .wet_rd_en(wet_rd_en), .wet_rd_addr(wet_rd_addr), .wet_rd_data(wet_rd_data),
    .PE_mac_enable(PE_mac_enable), .PE_clear_acc(PE_clear_acc),
    .PE_act_in(PE_act_in), .PE_wet_in(PE_wet_in),
    .PE_res_shift_num(PE_res_shift_num), .PE_result_out(PE_result_out),
    .oa_wr_en(oa_wr_en), .oa_wr_addr(oa_wr_addr), .oa_wr_data(oa_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int beats, clears, n_writes, addr_leak;

  typedef struct { logic [3:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  logic [7:0]  ia [0:7][0:7];   // ia[row][col]
  logic [7:0]  w  [0:7][0:7];   // w[row][col]
  logic [31:0] ia_mem  [0:15];
  logic [7:0]  wet_mem [0:63];

  // Buffers: data presented while the strobe is high, captured by the sequencer at the edge
  assign ia_rd_data  = ia_rd_en  ? ia_mem[ia_rd_addr]   : 32'd0;
  assign wet_rd_data = wet_rd_en ? wet_mem[wet_rd_addr] : 8'd0;

  function automatic logic signed [31:0] sx8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic [7:0] lane_res(input logic signed [31:0] a, input logic [7:0] sh);
    logic signed [31:0] t;
    t = a >>> sh;
    return t[7:0];
  endfunction

  // Behavioural pe_array: accumulate on enable; readout is captured on the first clear cycle
  logic signed [31:0] acc [0:3];
  logic [31:0] stage_r;
  logic        clr_prev;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) acc[n] <= 32'sd0;
      stage_r       <= 32'd0;
      PE_result_out <= 32'd0;
      clr_prev      <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (PE_clear_acc) acc[n] <= 32'sd0;
        else if (PE_mac_enable) acc[n] <= acc[n] + sx8(PE_act_in[n*8 +: 8]) * sx8(PE_wet_in);
        if (PE_clear_acc && !clr_prev) stage_r[n*8 +: 8] <= lane_res(acc[n], PE_res_shift_num);
      end
      PE_result_out <= stage_r;
      clr_prev      <= PE_clear_acc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 8; i++)
        for (int n = 0; n < 4; n++) ia_mem[j*8+i][n*8 +: 8] = ia[j*4+n][i];
    for (int i = 0; i < 8; i++)
      for (int m = 0; m < 8; m++) wet_mem[i*8+m] = w[i][m];
  endtask

  task automatic randomize_data();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ia[r][c] = 8'($urandom_range(0, 255));
        w[r][c]  = 8'($urandom_range(0, 255));
      end
  endtask

  // Golden matrix product, queued in m-outer / j-inner write order
  task automatic build_expected(input logic [7:0] sh);
    wr_t e;
    logic signed [31:0] sum;
    exp_q.delete();
    for (int m = 0; m < 8; m++)
      for (int j = 0; j < 2; j++) begin
        e.addr = 4'(j*8 + m);
        for (int n = 0; n < 4; n++) begin
          sum = 32'sd0;
          for (int i = 0; i < 8; i++) sum = sum + sx8(ia[j*4+n][i]) * sx8(w[i][m]);
          e.data[n*8 +: 8] = lane_res(sum, sh);
        end
        exp_q.push_back(e);
      end
  endtask

  // Per-cycle protocol observation and scoreboard compare on each output write
  task automatic observe();
    wr_t e;
    if (PE_mac_enable) beats++;
    if (PE_clear_acc) clears++;
    if ((!ia_rd_en && ia_rd_addr != 4'd0) || (!wet_rd_en && wet_rd_addr != 6'd0) ||
        (!oa_wr_en && oa_wr_addr != 4'd0)) addr_leak++;
    if (oa_wr_en) begin
      n_writes++;
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(oa_wr_addr), 64'(e.addr));
        chk("wr_data", 64'(oa_wr_data), 64'(e.data));
      end
      chk("mac_beats", 64'(beats), 64'd8);
      chk("clear_cycles", 64'(clears), 64'd3);
      beats  = 0;
      clears = 0;
    end
  endtask

  task automatic run_layer(input logic [7:0] sh, input bit poke, input int abort_at);
    int cyc, done_at, busy_low;
    beats = 0; clears = 0; n_writes = 0; addr_leak = 0;
    busy_low = 0; done_at = 0;
    @(negedge clk);
    chk("done_pulse_low", 64'(done), 64'd0);
    start = 1'b1; shift_num = sh;
    @(negedge clk);
    start = 1'b0; shift_num = 8'd0;
    cyc = 1;
    while (done_at == 0 && cyc < 400 && cyc != abort_at) begin
      observe();
      if (poke && cyc == 50) begin start = 1'b1; shift_num = 8'd3; end
      if (poke && cyc == 51) begin start = 1'b0; shift_num = 8'd0; end
      if (done === 1'b1) begin
        done_at = cyc;
      end else begin
        if (busy !== 1'b1) busy_low++;
        @(negedge clk);
        cyc++;
      end
    end
    if (abort_at == 0) begin
      chk("start_to_done", 64'(done_at), 64'd209);
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("busy_gaps", 64'(busy_low), 64'd0);
      chk("write_count", 64'(n_writes), 64'd16);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      chk("addr_outside_strobe", 64'(addr_leak), 64'd0);
      chk("shift_latched", 64'(PE_res_shift_num), 64'(sh));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    reset = 1'b1; start = 1'b0; shift_num = 8'd0;
    repeat (2) @(negedge clk);
    // start together with reset must be ignored
    start = 1'b1; shift_num = 8'h55;
    @(negedge clk);
    start = 1'b0; shift_num = 8'd0;
    chk("reset_ctrl", 64'({busy, done, ia_rd_en, wet_rd_en, PE_mac_enable, PE_clear_acc, oa_wr_en}), 64'd0);
    chk("reset_addr", 64'({ia_rd_addr, wet_rd_addr, oa_wr_addr}), 64'd0);
    chk("reset_pe_data", 64'({PE_act_in, PE_wet_in, PE_res_shift_num}), 64'd0);
    chk("reset_oa_data", 64'(oa_wr_data), 64'd0);
    reset = 1'b0;

    // All-ones activations, identity weights, no shift: every lane reads 1
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ia[r][c] = 8'd1;
        w[r][c]  = (r == c) ? 8'd1 : 8'd0;
      end
    load_mem();
    build_expected(8'd0);
    run_layer(8'd0, 1'b0, 0);

    // Random signed data, shift 8, with an ignored start (shift 3) while busy
    randomize_data();
    load_mem();
    build_expected(8'd8);
    run_layer(8'd8, 1'b1, 0);

    // Reset during the FEED phase of the fifth tile
    randomize_data();
    load_mem();
    build_expected(8'd2);
    run_layer(8'd2, 1'b0, 55);
    chk("writes_before_reset", 64'(n_writes), 64'd4);
    reset = 1'b1;
    #1;
    chk("midrst_ctrl", 64'({busy, done, ia_rd_en, wet_rd_en, PE_mac_enable, PE_clear_acc, oa_wr_en}), 64'd0);
    chk("midrst_addr", 64'({ia_rd_addr, wet_rd_addr, oa_wr_addr}), 64'd0);
    chk("midrst_pe_data", 64'({PE_act_in, PE_wet_in, PE_res_shift_num}), 64'd0);
    chk("midrst_oa_data", 64'(oa_wr_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (oa_wr_en || busy) stray++;
    end
    chk("quiet_after_reset", 64'(stray), 64'd0);
    exp_q.delete();

    // Restart after reset, then a back-to-back layer started in the cycle after done
    randomize_data();
    load_mem();
    build_expected(8'd4);
    run_layer(8'd4, 1'b0, 0);
    build_expected(8'd5);
    run_layer(8'd5, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
